// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline types and widths used by the fetch-stage control.
// Pure declarations: no logic, no latency, no flow control.
package rv_pipe_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        PEND  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Turns an absolute redirect destination into the PC-relative offset the PC register adds.
// Purely combinational; no backpressure.
module pc_target_calc
    import rv_pipe_pkg::*;
(
    input  logic [XLEN-1:0] abs_tgt,
    input  logic [XLEN-1:0] Pc,
    output logic [XLEN-1:0] rel_tgt,
    output logic            misalign
);

    localparam int ALIGN_BITS = $clog2(INSTR_BYTES);

    // Two's-complement wrap is intended; the PC register wraps the same way.
    assign rel_tgt  = abs_tgt - Pc;
    assign misalign = |abs_tgt[ALIGN_BITS-1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control: PC register and IF/ID, ID/EX write/flush steering; Mealy outputs, same-edge action.
// Stalls on Imem_ready=0 or load-use; a redirect seen while memory is busy is parked in PEND until ready.
module fetch_sequencer
    import rv_pipe_pkg::*;
#(
    parameter int BOOT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] Pc,
    input  logic        Imem_ready,
    input  logic        Load_use_stall,
    input  logic        Br_taken,
    input  logic [31:0] Br_pc,
    input  logic [31:0] Br_imm,
    input  logic        Halt,
    output logic        Enable,
    output logic        PCWrite,
    output logic        Control,
    output logic [31:0] Target,
    output logic        Imem_req,
    output logic        IfId_write,
    output logic        IfId_flush,
    output logic        IdEx_flush,
    output logic        Err_misalign,
    output logic [31:0] Stall_count
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    fetch_state_t state, state_nxt;
    logic [3:0]   boot_cnt;
    logic [31:0]  pend_tgt;
    logic [31:0]  br_tgt;
    logic [31:0]  abs_tgt;
    logic [31:0]  rel_tgt;
    logic         misalign;
    logic         load_pend;
    logic         set_err;

    assign br_tgt  = Br_pc + Br_imm;
    // One offset calculator serves both the direct and the parked redirect.
    assign abs_tgt = (state == PEND) ? pend_tgt : br_tgt;

    pc_target_calc u_tgt (
        .abs_tgt  (abs_tgt),
        .Pc       (Pc),
        .rel_tgt  (rel_tgt),
        .misalign (misalign)
    );

    always_comb begin
        state_nxt  = state;
        Enable     = 1'b0;
        PCWrite    = 1'b0;
        Control    = 1'b0;
        Target     = '0;
        Imem_req   = 1'b0;
        IfId_write = 1'b0;
        IfId_flush = 1'b0;
        IdEx_flush = 1'b0;
        load_pend  = 1'b0;
        set_err    = 1'b0;
        if (Reset_n) begin
            case (state)
                BOOT: begin
                    if (boot_cnt == BOOT_LAST) state_nxt = FETCH;
                end
                FETCH: begin
                    Enable   = 1'b1;
                    Imem_req = 1'b1;
                    if (Halt) begin
                        state_nxt = HALT;
                    end else if (Br_taken) begin
                        if (misalign) begin
                            set_err   = 1'b1;
                            state_nxt = HALT;
                        end else begin
                            IfId_flush = 1'b1;
                            IdEx_flush = 1'b1;
                            if (Imem_ready) begin
                                PCWrite = 1'b1;
                                Control = 1'b1;
                                Target  = rel_tgt;
                            end else begin
                                load_pend = 1'b1;
                                state_nxt = PEND;
                            end
                        end
                    end else if (!Imem_ready) begin
                        // memory wait: hold PC and IF/ID
                    end else if (Load_use_stall) begin
                        IdEx_flush = 1'b1;
                    end else begin
                        PCWrite    = 1'b1;
                        IfId_write = 1'b1;
                    end
                end
                PEND: begin
                    Enable   = 1'b1;
                    Imem_req = 1'b1;
                    if (Halt) begin
                        state_nxt = HALT;
                    end else if (Imem_ready) begin
                        PCWrite    = 1'b1;
                        Control    = 1'b1;
                        Target     = rel_tgt;
                        IfId_flush = 1'b1;
                        state_nxt  = FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state        <= BOOT;
            boot_cnt     <= '0;
            pend_tgt     <= '0;
            Err_misalign <= 1'b0;
            Stall_count  <= '0;
        end else begin
            state <= state_nxt;
            if (state == BOOT) boot_cnt <= boot_cnt + 4'd1;
            if (load_pend) pend_tgt <= br_tgt;
            if (set_err) Err_misalign <= 1'b1;
            if ((state == FETCH || state == PEND) && !PCWrite)
                Stall_count <= Stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer with a behavioural PC register model.
// Each vector is one clock cycle: inputs driven after negedge, outputs checked 1ns later.
module tb_fetch_sequencer;

    // expected control bits {Enable,PCWrite,Control,Imem_req,IfId_write,IfId_flush,IdEx_flush}
    localparam logic [6:0] IDLE = 7'b000_0000;
    localparam logic [6:0] ADV  = 7'b110_1100;
    localparam logic [6:0] BR   = 7'b111_1011;
    localparam logic [6:0] BRP  = 7'b100_1011;
    localparam logic [6:0] WAIT = 7'b100_1000;
    localparam logic [6:0] PRES = 7'b111_1010;
    localparam logic [6:0] LUS  = 7'b100_1001;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        lus;
        logic        br;
        logic [31:0] br_pc;
        logic [31:0] br_imm;
        logic        halt;
        logic [6:0]  ctl;
        logic [31:0] tgt;
        logic        err;
        logic [31:0] pc;
        logic [31:0] stall;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] Pc = '0;
    logic        Imem_ready = 1'b0;
    logic        Load_use_stall = 1'b0;
    logic        Br_taken = 1'b0;
    logic [31:0] Br_pc = '0;
    logic [31:0] Br_imm = '0;
    logic        Halt = 1'b0;
    logic        Enable, PCWrite, Control, Imem_req, IfId_write, IfId_flush, IdEx_flush;
    logic        Err_misalign;
    logic [31:0] Target, Stall_count;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_miss = 0;
    vec_t tbl[$];

    fetch_sequencer #(.BOOT_CYCLES(2)) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .Pc             (Pc),
        .Imem_ready     (Imem_ready),
        .Load_use_stall (Load_use_stall),
        .Br_taken       (Br_taken),
        .Br_pc          (Br_pc),
        .Br_imm         (Br_imm),
        .Halt           (Halt),
        .Enable         (Enable),
        .PCWrite        (PCWrite),
        .Control        (Control),
        .Target         (Target),
        .Imem_req       (Imem_req),
        .IfId_write     (IfId_write),
        .IfId_flush     (IfId_flush),
        .IdEx_flush     (IdEx_flush),
        .Err_misalign   (Err_misalign),
        .Stall_count    (Stall_count)
    );

    always #5 Clk = ~Clk;

    // PC register: adds Target or 4 on enabled writes, cleared by reset.
    always @(posedge Clk) begin
        if (!Reset_n)
            Pc <= '0;
        else if (Enable && PCWrite)
            Pc <= Pc + (Control ? Target : 32'd4);
    end

    function automatic vec_t mk(input logic rst_n, input logic rdy, input logic lus,
                                input logic br, input logic [31:0] br_pc,
                                input logic [31:0] br_imm, input logic halt,
                                input logic [6:0] ctl, input logic [31:0] tgt,
                                input logic err, input logic [31:0] pc,
                                input logic [31:0] stall);
        vec_t v;
        v.rst_n = rst_n; v.rdy = rdy; v.lus = lus; v.br = br;
        v.br_pc = br_pc; v.br_imm = br_imm; v.halt = halt;
        v.ctl = ctl; v.tgt = tgt; v.err = err; v.pc = pc; v.stall = stall;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [6:0] ctl_act;
        @(negedge Clk);
        Reset_n        = v.rst_n;
        Imem_ready     = v.rdy;
        Load_use_stall = v.lus;
        Br_taken       = v.br;
        Br_pc          = v.br_pc;
        Br_imm         = v.br_imm;
        Halt           = v.halt;
        #1;
        ctl_act = {Enable, PCWrite, Control, Imem_req, IfId_write, IfId_flush, IdEx_flush};
        n_vec++;
        chk("ctl",   idx, 32'(ctl_act), 32'(v.ctl));
        chk("tgt",   idx, Target, v.tgt);
        chk("pc",    idx, Pc, v.pc);
        chk("err",   idx, 32'(Err_misalign), 32'(v.err));
        chk("stall", idx, Stall_count, v.stall);
    endtask

    initial begin
        // reset held for three edges; registered outputs must be cleared
        Reset_n = 1'b0;
        Imem_ready = 1'b1;
        repeat (3) @(posedge Clk);
        apply(mk(0,1,0,0,0,0,0, IDLE, 0, 0, 32'h0, 0), 900);

        // boot, advance, direct redirect
        tbl.push_back(mk(1,1,0,0,0,0,0, IDLE, 0, 0, 32'h0, 0));
        tbl.push_back(mk(1,1,0,0,0,0,0, IDLE, 0, 0, 32'h0, 0));
        tbl.push_back(mk(1,1,0,0,0,0,0, ADV,  0, 0, 32'h0, 0));
        tbl.push_back(mk(1,1,0,0,0,0,0, ADV,  0, 0, 32'h4, 0));
        tbl.push_back(mk(1,1,0,0,0,0,0, ADV,  0, 0, 32'h8, 0));
        for (int a = 'hC; a <= 'h1C; a += 4)
            tbl.push_back(mk(1,1,0,0,0,0,0, ADV, 0, 0, 32'(a), 0));
        tbl.push_back(mk(1,1,0,1,32'h18,32'h100,0, BR, 32'hF8, 0, 32'h20, 0));
        tbl.push_back(mk(1,1,0,0,0,0,0, ADV, 0, 0, 32'h118, 0));
        // pending redirect, branch/stall ignored while parked
        tbl.push_back(mk(1,0,0,1,32'h18,32'h100,0, BRP, 0, 0, 32'h11C, 0));
        tbl.push_back(mk(1,0,0,0,0,0,0, WAIT, 0, 0, 32'h11C, 1));
        tbl.push_back(mk(1,0,1,1,32'h400,32'h0,0, WAIT, 0, 0, 32'h11C, 2));
        tbl.push_back(mk(1,1,0,0,0,0,0, PRES, 32'hFFFF_FFFC, 0, 32'h11C, 3));
        tbl.push_back(mk(1,1,0,0,0,0,0, ADV, 0, 0, 32'h118, 3));
        // load-use alone, branch beating load-use, memory wait beating load-use
        tbl.push_back(mk(1,1,1,0,0,0,0, LUS, 0, 0, 32'h11C, 3));
        tbl.push_back(mk(1,1,1,1,32'h11C,32'h10,0, BR, 32'h10, 0, 32'h11C, 4));
        tbl.push_back(mk(1,0,1,0,0,0,0, WAIT, 0, 0, 32'h12C, 4));
        // backward jump to 0x8, then wrap-around target, then halt
        tbl.push_back(mk(1,1,0,1,32'h0,32'h8,0, BR, 32'hFFFF_FEDC, 0, 32'h12C, 5));
        tbl.push_back(mk(1,1,0,1,32'h4,32'hFFFF_FFF8,0, BR, 32'hFFFF_FFF4, 0, 32'h8, 5));
        tbl.push_back(mk(1,1,0,0,0,0,1, WAIT, 0, 0, 32'hFFFF_FFFC, 5));
        tbl.push_back(mk(1,1,0,0,0,0,0, IDLE, 0, 0, 32'hFFFF_FFFC, 6));
        tbl.push_back(mk(1,1,1,1,32'h0,32'h20,0, IDLE, 0, 0, 32'hFFFF_FFFC, 6));
        // reset, reboot, misaligned redirect
        tbl.push_back(mk(0,1,0,0,0,0,0, IDLE, 0, 0, 32'hFFFF_FFFC, 6));
        tbl.push_back(mk(1,1,0,0,0,0,0, IDLE, 0, 0, 32'h0, 0));
        tbl.push_back(mk(1,1,0,0,0,0,0, IDLE, 0, 0, 32'h0, 0));
        tbl.push_back(mk(1,1,0,0,0,0,0, ADV,  0, 0, 32'h0, 0));
        tbl.push_back(mk(1,1,0,1,32'h40,32'h2,0, WAIT, 0, 0, 32'h4, 0));
        tbl.push_back(mk(1,1,0,0,0,0,0, IDLE, 0, 1, 32'h4, 1));
        tbl.push_back(mk(1,1,1,1,32'h0,32'h8,0, IDLE, 0, 1, 32'h4, 1));
        tbl.push_back(mk(0,1,0,0,0,0,0, IDLE, 0, 1, 32'h4, 1));
        tbl.push_back(mk(1,1,0,0,0,0,0, IDLE, 0, 0, 32'h0, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        // reset while a redirect is parked: the parked target must not survive
        apply(mk(1,1,0,0,0,0,0, IDLE, 0, 0, 32'h0, 0), 100);
        apply(mk(1,1,0,0,0,0,0, ADV,  0, 0, 32'h0, 0), 101);
        apply(mk(1,0,0,1,32'h100,32'h0,0, BRP, 0, 0, 32'h4, 0), 102);
        apply(mk(0,1,0,0,0,0,0, IDLE, 0, 0, 32'h4, 1), 103);
        apply(mk(1,1,0,0,0,0,0, IDLE, 0, 0, 32'h0, 0), 104);
        apply(mk(1,1,0,0,0,0,0, IDLE, 0, 0, 32'h0, 0), 105);
        apply(mk(1,1,0,0,0,0,0, ADV,  0, 0, 32'h0, 0), 106);

        // halt while parked beats the ready redirect
        apply(mk(1,0,0,1,32'h100,32'h0,0, BRP, 0, 0, 32'h4, 0), 200);
        apply(mk(1,1,0,0,0,0,1, WAIT, 0, 0, 32'h4, 1), 201);
        apply(mk(1,1,0,0,0,0,0, IDLE, 0, 0, 32'h4, 2), 202);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
